// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronised, de-glitched scl/sda, 11-bit frame deframer with
// parity/stop/timeout checks, optional E0/F0 prefix folding, and a first-word-fall-through FIFO.
module ps2_rx_fifo #(
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter bit          DECODE_EN   = 1'b1
) (
  input  logic                          ck,
  input  logic                          reset,
  input  logic                          scl,
  input  logic                          sda,
  input  logic                          rd_en,
  output logic [9:0]                    data_out,
  output logic                          data_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int unsigned FCW = $clog2(FILT_LEN + 1);
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_e;

  // ---------------- input synchronisers and scl glitch filter ----------------
  logic           scl_meta_q, scl_sync_q, sda_meta_q, sda_sync_q;
  logic           scl_filt_q, scl_filt_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           strobe_q, strobe_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    scl_filt_d = scl_filt_q;
    filt_cnt_d = filt_cnt_q;
    strobe_d   = 1'b0;
    if (scl_sync_q == scl_filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FCW'(FILT_LEN - 1)) begin
      filt_cnt_d = '0;
      scl_filt_d = scl_sync_q;
      strobe_d   = ~scl_sync_q;
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      scl_filt_q <= 1'b1;
      filt_cnt_q <= '0;
      strobe_q   <= 1'b0;
    end else begin
      scl_meta_q <= scl;
      scl_sync_q <= scl_meta_q;
      sda_meta_q <= sda;
      sda_sync_q <= sda_meta_q;
      scl_filt_q <= scl_filt_d;
      filt_cnt_q <= filt_cnt_d;
      strobe_q   <= strobe_d;
    end
  end

  // ---------------- deframer FSM with watchdog ----------------
  state_e         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           byte_evt_q, byte_evt_d;
  logic           frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    byte_evt_d  = 1'b0;
    frame_err_d = 1'b0;
    wd_d        = (state_q == ST_IDLE || strobe_q) ? '0 : wd_q + 1'b1;

    if (strobe_q) begin
      unique case (state_q)
        ST_IDLE: if (!sda_sync_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
        ST_DATA: begin
          shift_d   = {sda_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = sda_sync_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if ((^{shift_q, par_q}) && sda_sync_q) byte_evt_d  = 1'b1;
          else                                   frame_err_d = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && wd_q == WDW'(TIMEOUT_CYC - 1)) begin
      // Stalled frame: abandon it without producing a byte.
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      wd_d        = '0;
    end
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      wd_q        <= '0;
      byte_evt_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      wd_q        <= wd_d;
      byte_evt_q  <= byte_evt_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------- prefix decoder and FIFO ----------------
  logic          ext_q, ext_d, brk_q, brk_d;
  logic          push, pop, full, wr_en, ovf_d, ovf_q;
  logic [9:0]    push_data;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [9:0]    mem [FIFO_DEPTH];

  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    push      = 1'b0;
    push_data = {ext_q, brk_q, shift_q};
    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_evt_q) begin
      if (DECODE_EN && shift_q == 8'hE0)      ext_d = 1'b1;
      else if (DECODE_EN && shift_q == 8'hF0) brk_d = 1'b1;
      else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end

    pop      = rd_en && (count_q != '0);
    full     = (count_q == CW'(FIFO_DEPTH));
    // When full, a simultaneous pop frees the head slot that wr_ptr already points at.
    wr_en    = push && (!full || pop);
    ovf_d    = push && full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(pop);
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage array is not reset; occupancy is tracked by count_q, and the output is masked when empty.
  always_ff @(posedge ck) begin
    if (wr_en) mem[wr_ptr_q] <= push_data;
  end

  assign data_out   = (count_q != '0) ? mem[rd_ptr_q] : '0;
  assign data_valid = (count_q != '0);
  assign count      = count_q;
  assign frame_err  = frame_err_q;
  assign overflow   = ovf_q;

endmodule
